// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control sequencer: default opcodes,
// instruction field positions, FSM state encoding and the decoded-field bundle.
// Contents: OP_* opcode defaults, *_LSB field offsets, state_t, fields_t.
package cpu_pkg;

    localparam logic [3:0] OP_JMP  = 4'd9;
    localparam logic [3:0] OP_BEQZ = 4'd8;
    localparam logic [3:0] OP_HALT = 4'd15;

    // Least-significant bit of each field within the 16-bit instruction word.
    localparam int OP_LSB   = 12;
    localparam int RD_LSB   = 9;
    localparam int RS_LSB   = 6;
    localparam int RT_LSB   = 3;
    localparam int FUNC_LSB = 0;
    localparam int IMM_LSB  = 0;
    localparam int JOFF_LSB = 0;

    typedef enum logic [1:0] {
        FETCH,
        DECODE,
        EXEC,
        HALT
    } state_t;

    typedef struct packed {
        logic [3:0] op;
        logic [2:0] rd;
        logic [2:0] rs;
        logic [2:0] rt;
        logic [2:0] func;
        logic [5:0] imm;
        logic [7:0] jump_offset;
    } fields_t;

endpackage

// File: rtl/cpu_control_sequencer_if.sv
// Bundle of the sequencer's instruction-memory, datapath and status signals.
// Modport seq is the sequencer side; modport env is the memory/datapath side.
// Ports: imem_* fetch handshake, decoded fields, exec_start/exec_done/zero, pc, halted.
interface cpu_control_sequencer_if #(
    parameter int PC_W = 8
);

    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_valid;
    logic [15:0]     imem_rdata;
    logic [3:0]      op;
    logic [2:0]      rd;
    logic [2:0]      rs;
    logic [2:0]      rt;
    logic [2:0]      func;
    logic [5:0]      imm;
    logic [7:0]      jump_offset;
    logic            exec_start;
    logic            exec_done;
    logic            zero;
    logic [PC_W-1:0] pc;
    logic            halted;

    modport seq (
        output imem_req, imem_addr, op, rd, rs, rt, func, imm, jump_offset,
               exec_start, pc, halted,
        input  imem_valid, imem_rdata, exec_done, zero
    );

    modport env (
        input  imem_req, imem_addr, op, rd, rs, rt, func, imm, jump_offset,
               exec_start, pc, halted,
        output imem_valid, imem_rdata, exec_done, zero
    );

endinterface

// File: rtl/inst_decoder.sv
// Combinational field slicer from a 16-bit instruction word to its fields.
// Latency: 0 cycles (pure combinational). Backpressure: none.
// Ports: inst_i instruction word in, fields_o decoded field bundle out.
module inst_decoder
    import cpu_pkg::*;
(
    input  logic [15:0] inst_i,
    output fields_t     fields_o
);

    assign fields_o.op          = inst_i[OP_LSB   +: 4];
    assign fields_o.rd          = inst_i[RD_LSB   +: 3];
    assign fields_o.rs          = inst_i[RS_LSB   +: 3];
    assign fields_o.rt          = inst_i[RT_LSB   +: 3];
    assign fields_o.func        = inst_i[FUNC_LSB +: 3];
    assign fields_o.imm         = inst_i[IMM_LSB  +: 6];
    assign fields_o.jump_offset = inst_i[JOFF_LSB +: 8];

endmodule

// File: rtl/cpu_control_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC sequencer owning the PC; halts on OP_HALT.
// Latency: 3 cycles per instruction, +1 per cycle of late imem_valid or exec_done.
// Backpressure: imem_req held until imem_valid; EXEC waits indefinitely for exec_done.
// Ports: clk, rst (async active-low), bus (seq modport: fetch, decode, exec, status).
module cpu_control_sequencer
    import cpu_pkg::state_t, cpu_pkg::fields_t,
           cpu_pkg::FETCH, cpu_pkg::DECODE, cpu_pkg::EXEC, cpu_pkg::HALT;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [3:0]      OP_JMP   = cpu_pkg::OP_JMP,
    parameter logic [3:0]      OP_BEQZ  = cpu_pkg::OP_BEQZ,
    parameter logic [3:0]      OP_HALT  = cpu_pkg::OP_HALT
) (
    input  logic                  clk,
    input  logic                  rst,
    cpu_control_sequencer_if.seq  bus
);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     inst_q, inst_d;
    fields_t         fields_q, fields_d;
    logic            exec_start_q, exec_start_d;
    logic            imem_req_q, imem_req_d;

    fields_t         dec;
    logic [PC_W-1:0] off_ext;
    logic            take_offset;
    logic [PC_W-1:0] pc_next;

    inst_decoder u_dec (
        .inst_i   (inst_q),
        .fields_o (dec)
    );

    // Offset is sign-extended for wide PCs and truncated for narrow ones.
    generate
        if (PC_W > 8) begin : g_sext
            assign off_ext = {{(PC_W-8){fields_q.jump_offset[7]}}, fields_q.jump_offset};
        end else begin : g_trunc
            assign off_ext = fields_q.jump_offset[PC_W-1:0];
        end
    endgenerate

    assign take_offset = (fields_q.op == OP_JMP) ||
                         ((fields_q.op == OP_BEQZ) && bus.zero);
    assign pc_next     = take_offset ? (pc_q + off_ext) : (pc_q + PC_W'(1));

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        fields_d     = fields_q;
        exec_start_d = 1'b0;
        case (state_q)
            FETCH: begin
                // A word is only taken while the request is actually on the port.
                if (imem_req_q && bus.imem_valid) begin
                    inst_d  = bus.imem_rdata;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                fields_d = dec;
                if (dec.op == OP_HALT) begin
                    state_d = HALT;
                end else begin
                    // Registered so the pulse lines up with the freshly
                    // registered fields in the first EXEC cycle.
                    exec_start_d = 1'b1;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                if (bus.exec_done) begin
                    pc_d    = pc_next;
                    state_d = FETCH;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
        // Request is registered so it stays low while in reset and rises
        // on the first edge after release.
        imem_req_d = (state_d == FETCH);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            fields_q     <= '0;
            exec_start_q <= 1'b0;
            imem_req_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            fields_q     <= fields_d;
            exec_start_q <= exec_start_d;
            imem_req_q   <= imem_req_d;
        end
    end

    assign bus.imem_req    = imem_req_q;
    assign bus.imem_addr   = pc_q;
    assign bus.pc          = pc_q;
    assign bus.op          = fields_q.op;
    assign bus.rd          = fields_q.rd;
    assign bus.rs          = fields_q.rs;
    assign bus.rt          = fields_q.rt;
    assign bus.func        = fields_q.func;
    assign bus.imm         = fields_q.imm;
    assign bus.jump_offset = fields_q.jump_offset;
    assign bus.exec_start  = exec_start_q;
    assign bus.halted      = (state_q == HALT);

endmodule
